// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// requesters. A requester wins the port for a burst of up to MAX_BURST
// accepted beats, then the port rotates to the next active requester.
// One IDLE cycle separates bursts. That cycle is where arbitration happens.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst_n          in   asynchronous active-low reset
//   req            in   [NUM_REQ]            per-requester write request
//   req_data       in   [NUM_REQ*DATA_WIDTH] packed data, requester i at
//                                            [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt            out  [NUM_REQ]            one-hot: beat of requester i
//                                            written this cycle
//   fifo_wr_en     out  FIFO write enable (owner's request while in BURST)
//   fifo_wr_data   out  [DATA_WIDTH]         owner's data
//   fifo_wr_ready  in   FIFO can accept a write (not full)
//   owner_id       out  [$clog2(NUM_REQ)]    current / last burst owner
//   busy           out  high while a burst is in progress
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_ready,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic                          busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q,  last_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pick_valid;
    logic [OW-1:0]   pick_id;
    logic            owner_req;
    logic            beat;
    logic            last_beat;

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req bit searching upward from last_q+1,
    // wrapping. The loop runs from the farthest candidate to the nearest so
    // the nearest active requester is the final (winning) assignment.
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves a signal unassigned would infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_id    = OW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    assign owner_req = req[owner_q];
    assign beat      = (state_q == BURST) && owner_req && fifo_wr_ready;
    assign last_beat = beat && ((count_q + CW'(1)) == CW'(MAX_BURST));

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state plus the live owner request and
    // FIFO ready. Nothing is driven outside BURST, so an async reset clears
    // every output as soon as the state register clears.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt          = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        if (state_q == BURST) begin
            busy         = 1'b1;
            fifo_wr_en   = owner_req;
            fifo_wr_data = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            gnt[owner_q] = owner_req && fifo_wr_ready;
        end
    end

    assign owner_id = owner_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_id;
                    count_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    // Owner withdrew with no beat pending: release the port.
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (beat) begin
                    count_d = count_q + CW'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
                // A stall (owner_req && !fifo_wr_ready) holds everything.
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register. last_q resets to NUM_REQ-1 so requester 0 is searched
    // first after reset.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_gnt_implies_write : assert property (@(posedge clk) disable iff (!rst_n)
        (gnt != '0) |-> (fifo_wr_en && fifo_wr_ready));
    a_wr_en_implies_busy : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_wr_en |-> busy);
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        int'(count_q) <= MAX_BURST);
    a_no_gnt_in_reset : assert property (@(posedge clk)
        !rst_n |-> (gnt == '0));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. The reference model tracks the arbiter at the level of
// "who owns the port and how many beats it has taken".
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int OW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_ready;
    logic [OW-1:0]     owner_id;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_ready(fifo_wr_ready),
        .owner_id     (owner_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy;
    int m_owner, m_last, m_beats;

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_beats = 0;
    endfunction

    // Expected outputs for the current inputs; returns the expected grant.
    task automatic model_compare(output logic [N-1:0] eg);
        logic          ee;
        logic [DW-1:0] ed;
        eg = '0;
        ee = 1'b0;
        ed = '0;
        if (m_busy) begin
            ee = req[m_owner];
            ed = req_data[m_owner*DW +: DW];
            if (ee && fifo_wr_ready) eg[m_owner] = 1'b1;
        end
        check("gnt",      gnt,        eg);
        check("wr_en",    fifo_wr_en, ee);
        check("busy",     busy,       m_busy);
        check("owner_id", owner_id,   m_owner);
        if (ee) check("wr_data", fifo_wr_data, ed);
    endtask

    function automatic void model_step();
        if (!m_busy) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int c = (m_last + k) % N;
                    if (req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else if (fifo_wr_ready) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
    endfunction

    // ---------------- protocol-obeying requesters ----------------
    int            rem [N];
    int            seq [N];
    logic [DW-1:0] dat [N];
    bit            rnd_data = 1'b0;
    logic [DW-1:0] wr_log [$];
    logic [DW-1:0] exp_log [$];

    task automatic load(input int i, input int n);
        rem[i] = n;
        seq[i] = 0;
        dat[i] = rnd_data ? DW'($urandom) : DW'(i * 16);
    endtask

    function automatic bit any_rem();
        for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive, compare on falling edge, advance model, update
    // requesters on the beats the model says were accepted.
    task automatic tick(input logic rdy);
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*DW +: DW] = dat[i];
        end
        fifo_wr_ready = rdy;
        @(negedge clk);
        model_compare(eg);
        if (fifo_wr_en && fifo_wr_ready) wr_log.push_back(fifo_wr_data);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
                rem[i]--;
                seq[i]++;
                dat[i] = rnd_data ? DW'($urandom) : DW'(i * 16 + seq[i]);
            end
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (any_rem() && t < 500) begin
            tick(1'b1);
            t++;
        end
        check(name, 32'(t < 500), 32'd1);
    endtask

    task automatic compare_log(input string name);
        check({name, "_len"}, wr_log.size(), exp_log.size());
        for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++)
            check($sformatf("%s[%0d]", name, i), wr_log[i], exp_log[i]);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req           = '0;
        req_data      = '0;
        fifo_wr_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
            dat[i] = '0;
        end
        model_reset();
        @(negedge clk);
        check("rst_busy",  busy,       1'b0);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_gnt",   gnt,        '0);
        check("rst_owner", owner_id,   '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_log.delete();
        exp_log.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic          rdy;
        logic [N-1:0]  gnt;
        logic          en;
        logic          busy;
        logic [OW-1:0] owner;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset idle for 10 cycles, then requester 2 alone with 6 beats:
        // 4 beats, bubble, 2 beats, then it drops req and the burst ends.
        for (int i = 0; i < 10; i++) tbl[i] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[10] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        for (int i = 11; i <= 14; i++) tbl[i] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h33};
        tbl[15] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h00};
        tbl[16] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h33};
        tbl[17] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h33};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h00};
        tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h00};

        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 20; i++) begin
            req           = tbl[i].req;
            fifo_wr_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", i),   gnt,        tbl[i].gnt);
            check($sformatf("tbl%0d_en", i),    fifo_wr_en, tbl[i].en);
            check($sformatf("tbl%0d_busy", i),  busy,       tbl[i].busy);
            check($sformatf("tbl%0d_owner", i), owner_id,   tbl[i].owner);
            if (tbl[i].en) check($sformatf("tbl%0d_data", i), fifo_wr_data, tbl[i].data);
            @(posedge clk);
            #1;
        end

        // All four request 8 beats: order 0,1,2,3,0,1,2,3, 4 beats per burst,
        // one idle cycle before each burst -> 40 cycles.
        begin
            int t = 0;
            do_reset();
            for (int i = 0; i < N; i++) load(i, 8);
            while (any_rem() && t < 200) begin
                tick(1'b1);
                t++;
            end
            check("rr_cycles", t, 40);
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < N; i++)
                    for (int b = 0; b < MB; b++) exp_log.push_back(DW'(i * 16 + r * MB + b));
            compare_log("rr_log");
        end

        // Requester 1 stalls 5 cycles after its 2nd beat; requester 0 joins
        // during the stall and gets the port after the rotation.
        do_reset();
        load(1, 4);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        load(0, 2);
        for (int s = 0; s < 5; s++) begin
            tick(1'b0);
            check("stall_gnt",   gnt,        '0);
            check("stall_wr_en", fifo_wr_en, 1'b1);
        end
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("rot_owner", owner_id, 2'd0);
        check("rot_busy",  busy,     1'b1);
        drain("stall_drain");
        exp_log = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h01};
        compare_log("stall_log");

        // Requester 3 drops after 1 beat; next owner wraps to 0. Then an
        // async reset pulse mid-burst of requester 0.
        do_reset();
        load(3, 1);
        tick(1'b1);
        load(0, 3);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("wrap_owner", owner_id, 2'd0);
        tick(1'b1);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_gnt",  gnt,  4'b0001);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy",  busy,       1'b0);
        check("async_rst_gnt",   gnt,        '0);
        check("async_rst_wr_en", fifo_wr_en, 1'b0);
        #1 rst_n = 1'b1;
        model_reset();
        load(2, 2);
        tick(1'b1);
        check("post_rst_owner", owner_id, 2'd0);
        check("post_rst_busy",  busy,     1'b1);
        drain("rst_drain");
        exp_log = '{8'h30, 8'h00, 8'h01, 8'h02, 8'h20, 8'h21};
        compare_log("rst_log");

        // Randomized traffic and back-pressure against the model.
        do_reset();
        rnd_data = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) load(i, int'($urandom_range(1, 10)));
            tick($urandom_range(0, 3) != 0);
        end
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
